// File: rtl/tile_plotter_if.sv
// Request / pixel-stream bundle for tile_plotter.
// master: the map-control side that issues cell requests and receives pixels.
// slave : the tile_plotter itself.
// When CLEAR_SCREEN_EN is defined the bundle also carries clear_req.
interface tile_plotter_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] cell_addr;
  logic [1:0] cell_type;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       done;
`ifdef CLEAR_SCREEN_EN
  logic       clear_req;

  modport master (
    output req_valid, cell_addr, cell_type, clear_req,
    input  req_ready, x, y, colour, plot, done
  );

  modport slave (
    input  req_valid, cell_addr, cell_type, clear_req,
    output req_ready, x, y, colour, plot, done
  );
`else
  modport master (
    output req_valid, cell_addr, cell_type,
    input  req_ready, x, y, colour, plot, done
  );

  modport slave (
    input  req_valid, cell_addr, cell_type,
    output req_ready, x, y, colour, plot, done
  );
`endif
endinterface

// File: rtl/tile_plotter.sv
// tile_plotter: turns one map-cell request into a row-major stream of
// TILE_W*TILE_H pixels (one per clock) for vga_adapter, then pulses done.
// Optional macro CLEAR_SCREEN_EN adds clear_req and a CLEAR state that
// blanks the whole 160x120 screen before returning through DONE.
module tile_plotter #(
  parameter int TILE_W   = 7,
  parameter int TILE_H   = 7,
  parameter int X_ORIGIN = 24,
  parameter int Y_ORIGIN = 4
) (
  input  logic          clk,
  input  logic          resetn,
  tile_plotter_if.slave bus
);

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

`ifdef CLEAR_SCREEN_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE, S_CLEAR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_t;
`endif

  state_t     state_q, state_d;
  logic [3:0] col_q, col_d;
  logic [3:0] row_q, row_d;
  logic [1:0] type_q, type_d;
  // px/py hold the coordinate of the pixel currently on the outputs
  logic [7:0] px_q, px_d;
  logic [6:0] py_q, py_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       done_q, done_d;
  logic       emit_tile;
  logic [8:0] base_x;
  logic [8:0] base_y;

  // Tile origin follows the latched cell; it is stable from LOAD onwards.
  assign base_x = 9'(X_ORIGIN) + 9'(col_q) * 9'(TILE_W);
  assign base_y = 9'(Y_ORIGIN) + 9'(row_q) * 9'(TILE_H);

  // Colour of one pixel inside a tile, by cell type.
  function automatic logic [2:0] tile_colour(input logic [1:0] t,
                                             input logic [7:0] cx,
                                             input logic [6:0] cy);
    logic corner;
    logic centre;
    corner = ((cx == 8'd0) || (cx == 8'(TILE_W - 1))) &&
             ((cy == 7'd0) || (cy == 7'(TILE_H - 1)));
    centre = (cx >= 8'(TILE_W / 2 - 1)) && (cx <= 8'(TILE_W / 2 + 1)) &&
             (cy >= 7'(TILE_H / 2 - 1)) && (cy <= 7'(TILE_H / 2 + 1));
    case (t)
      2'd0:    tile_colour = 3'b000;
      2'd1:    tile_colour = 3'b111;
      2'd2:    tile_colour = corner ? 3'b000 : 3'b010;
      default: tile_colour = centre ? 3'b100 : 3'b000;
    endcase
  endfunction

  // A clear request in IDLE blocks tile acceptance so it wins a tie.
`ifdef CLEAR_SCREEN_EN
  assign bus.req_ready = (state_q == S_IDLE) && !bus.clear_req;
`else
  assign bus.req_ready = (state_q == S_IDLE);
`endif
  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.done   = done_q;

  // Next state, pixel counters and the next registered pixel.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    type_d    = type_q;
    px_d      = px_q;
    py_d      = py_q;
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    plot_d    = 1'b0;
    done_d    = 1'b0;
    emit_tile = 1'b0;

    case (state_q)
      S_IDLE: begin
        px_d = 8'd0;
        py_d = 7'd0;
`ifdef CLEAR_SCREEN_EN
        if (bus.clear_req) begin
          state_d  = S_CLEAR;
          x_d      = 8'd0;
          y_d      = 7'd0;
          colour_d = 3'b000;
          plot_d   = 1'b1;
        end else
`endif
        if (bus.req_valid) begin
          state_d = S_LOAD;
          col_d   = bus.cell_addr[3:0];
          row_d   = bus.cell_addr[7:4];
          type_d  = bus.cell_type;
        end
      end

      S_LOAD: begin
        // First pixel of the tile goes out on the same edge that enters DRAW.
        state_d   = S_DRAW;
        px_d      = 8'd0;
        py_d      = 7'd0;
        emit_tile = 1'b1;
      end

      S_DRAW: begin
        if ((px_q == 8'(TILE_W - 1)) && (py_q == 7'(TILE_H - 1))) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          if (px_q == 8'(TILE_W - 1)) begin
            px_d = 8'd0;
            py_d = py_q + 7'd1;
          end else begin
            px_d = px_q + 8'd1;
          end
          emit_tile = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        px_d    = 8'd0;
        py_d    = 7'd0;
      end

`ifdef CLEAR_SCREEN_EN
      S_CLEAR: begin
        if ((px_q == 8'(SCREEN_W - 1)) && (py_q == 7'(SCREEN_H - 1))) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          if (px_q == 8'(SCREEN_W - 1)) begin
            px_d = 8'd0;
            py_d = py_q + 7'd1;
          end else begin
            px_d = px_q + 8'd1;
          end
          x_d      = px_d;
          y_d      = py_d;
          colour_d = 3'b000;
          plot_d   = 1'b1;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    if (emit_tile) begin
      x_d      = 8'(base_x + 9'(px_d));
      y_d      = 7'(base_y + 9'(py_d));
      colour_d = tile_colour(type_q, px_d, py_d);
      plot_d   = 1'b1;
    end
  end

  // State and output registers; reset abandons any tile or sweep in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      col_q    <= 4'd0;
      row_q    <= 4'd0;
      type_q   <= 2'd0;
      px_q     <= 8'd0;
      py_q     <= 7'd0;
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      colour_q <= 3'b000;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      type_q   <= type_d;
      px_q     <= px_d;
      py_q     <= py_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_tile_plotter.sv
// Self-checking bench for tile_plotter: directed tiles from the test plan plus
// random requests, each compared with a pixel-list reference model.
module tb_tile_plotter;
  localparam int TW = 7;
  localparam int TH = 7;
  localparam int XO = 24;
  localparam int YO = 4;
  localparam int NPIX = TW * TH;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  tile_plotter_if bus();

  tile_plotter #(.TILE_W(TW), .TILE_H(TH), .X_ORIGIN(XO), .Y_ORIGIN(YO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cap_x[$];
  int cap_y[$];
  int cap_c[$];
  int exp_x[$];
  int exp_y[$];
  int exp_c[$];
  int first_k, last_k, done_k, ready_seen, done_x, done_y;
  bit timed_out;

  // Reference: every pixel of a tile in row-major order, from the colour rules.
  task automatic model_tile(input int addr, input int typ);
    int bx, by, c;
    bit corner, centre;
    exp_x.delete(); exp_y.delete(); exp_c.delete();
    bx = XO + (addr % 16) * TW;
    by = YO + (addr / 16) * TH;
    for (int r = 0; r < TH; r++) begin
      for (int col = 0; col < TW; col++) begin
        corner = (r == 0 || r == TH - 1) && (col == 0 || col == TW - 1);
        centre = (col >= TW / 2 - 1) && (col <= TW / 2 + 1) &&
                 (r >= TH / 2 - 1) && (r <= TH / 2 + 1);
        case (typ)
          0:       c = 0;
          1:       c = 7;
          2:       c = corner ? 0 : 2;
          default: c = centre ? 4 : 0;
        endcase
        exp_x.push_back(bx + col);
        exp_y.push_back(by + r);
        exp_c.push_back(c);
      end
    end
  endtask

  // Present a request at a falling edge and return just after the accepting edge.
  task automatic issue(input logic [7:0] a, input logic [1:0] t, output bit ok, output int waits);
    ok = 1'b0;
    waits = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.cell_addr = a;
    bus.cell_type = t;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus.req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      waits++;
      @(negedge clk);
    end
    if (ok) @(posedge clk);
  endtask

  // Record the pixel stream after acceptance; k counts falling edges since it.
  task automatic collect(input bit hold, input logic [1:0] new_t, input int budget);
    cap_x.delete(); cap_y.delete(); cap_c.delete();
    first_k = -1; last_k = -1; done_k = -1; ready_seen = 0;
    done_x = -1; done_y = -1;
    timed_out = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) begin
          bus.cell_type = new_t;
        end else begin
          bus.req_valid = 1'b0;
          bus.cell_addr = 8'($urandom);
          bus.cell_type = 2'($urandom);
        end
      end
      #1;
      if (bus.req_ready === 1'b1) ready_seen = 1;
      if (bus.plot === 1'b1) begin
        cap_x.push_back(int'(bus.x));
        cap_y.push_back(int'(bus.y));
        cap_c.push_back(int'(bus.colour));
        if (first_k < 0) first_k = k;
        last_k = k;
      end
      if (bus.done === 1'b1) begin
        done_k = k;
        done_x = int'(bus.x);
        done_y = int'(bus.y);
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [21:0] got;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      got = {bus.req_ready, bus.plot, bus.done, bus.x, bus.y, bus.colour};
      checks++;
      if (got !== {1'b1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0}) begin
        errors++;
        $display("FAIL reset_state cycle %0d: got ready/plot/done/x/y/colour=%h, expected %h",
                 i, got, {1'b1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0});
      end
    end
    $display("reset: 10 idle cycles observed");
  endtask

  task automatic test_wall();
    bit ok;
    int waits;
    issue(8'h00, 2'd1, ok, waits);
    checks++;
    if (!ok) begin errors++; $display("FAIL wall_accept: req_ready never high"); return; end
    collect(1'b0, 2'd0, 200);
    model_tile(8'h00, 1);
    checks++;
    if (timed_out) begin errors++; $display("FAIL wall_done: no done within budget"); end
    checks++;
    if (cap_x.size() != NPIX) begin errors++; $display("FAIL wall_count: got %0d plots, expected %0d", cap_x.size(), NPIX); end
    checks++;
    if (first_k != 2) begin errors++; $display("FAIL wall_first_latency: got %0d, expected 2", first_k); end
    checks++;
    if (done_k != last_k + 1 || last_k != 1 + NPIX) begin
      errors++;
      $display("FAIL wall_done_timing: last plot k=%0d done k=%0d, expected %0d and %0d", last_k, done_k, 1 + NPIX, 2 + NPIX);
    end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (i >= cap_x.size()) begin
        errors++; $display("FAIL wall_pixel[%0d]: missing, expected (%0d,%0d) c%0d", i, exp_x[i], exp_y[i], exp_c[i]);
      end else if (cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i] || cap_c[i] != exp_c[i]) begin
        errors++;
        $display("FAIL wall_pixel[%0d]: got (%0d,%0d) c%0d, expected (%0d,%0d) c%0d",
                 i, cap_x[i], cap_y[i], cap_c[i], exp_x[i], exp_y[i], exp_c[i]);
      end
    end
    $display("tile addr=00 type=1 plots=%0d first=%0d done=%0d", cap_x.size(), first_k, done_k);
  endtask

  task automatic test_bullet();
    bit ok;
    int waits, centre_c, block4, all4;
    issue(8'hFF, 2'd3, ok, waits);
    checks++;
    if (!ok) begin errors++; $display("FAIL bullet_accept: req_ready never high"); return; end
    collect(1'b0, 2'd0, 200);
    model_tile(8'hFF, 3);
    checks++;
    if (cap_x.size() != NPIX || timed_out) begin
      errors++; $display("FAIL bullet_count: got %0d plots (timeout=%0d), expected %0d", cap_x.size(), timed_out, NPIX);
    end
    centre_c = -1; block4 = 0; all4 = 0;
    for (int i = 0; i < cap_x.size(); i++) begin
      if (cap_x[i] == 132 && cap_y[i] == 112) centre_c = cap_c[i];
      if (cap_c[i] == 4) all4++;
      if (cap_c[i] == 4 && cap_x[i] >= 131 && cap_x[i] <= 133 && cap_y[i] >= 111 && cap_y[i] <= 113) block4++;
    end
    checks++;
    if (centre_c != 4) begin errors++; $display("FAIL bullet_centre: colour at (132,112) got %0d, expected 4", centre_c); end
    checks++;
    if (block4 != 9 || all4 != 9) begin
      errors++; $display("FAIL bullet_block: colour-4 pixels in block %0d total %0d, expected 9 and 9", block4, all4);
    end
    checks++;
    if (cap_x.size() > 0) begin
      if (cap_x[0] != 129 || cap_y[0] != 109 || cap_c[0] != 0) begin
        errors++; $display("FAIL bullet_corner: got (%0d,%0d) c%0d, expected (129,109) c0", cap_x[0], cap_y[0], cap_c[0]);
      end
    end else begin
      errors++; $display("FAIL bullet_corner: no pixels, expected (129,109) c0");
    end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (i >= cap_x.size()) begin
        errors++; $display("FAIL bullet_pixel[%0d]: missing, expected (%0d,%0d) c%0d", i, exp_x[i], exp_y[i], exp_c[i]);
      end else if (cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i] || cap_c[i] != exp_c[i]) begin
        errors++;
        $display("FAIL bullet_pixel[%0d]: got (%0d,%0d) c%0d, expected (%0d,%0d) c%0d",
                 i, cap_x[i], cap_y[i], cap_c[i], exp_x[i], exp_y[i], exp_c[i]);
      end
    end
    $display("tile addr=ff type=3 plots=%0d centre_c=%0d", cap_x.size(), centre_c);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int waits;
    issue(8'h3A, 2'd2, ok, waits);
    checks++;
    if (!ok) begin errors++; $display("FAIL tank_accept: req_ready never high"); return; end
    // req_valid stays high and cell_type changes to empty during the tank tile
    collect(1'b1, 2'd0, 200);
    model_tile(8'h3A, 2);
    checks++;
    if (ready_seen != 0) begin errors++; $display("FAIL tank_ready_busy: req_ready seen high during tile, expected low"); end
    checks++;
    if (cap_x.size() != NPIX || timed_out) begin
      errors++; $display("FAIL tank_count: got %0d plots (timeout=%0d), expected %0d", cap_x.size(), timed_out, NPIX);
    end
    checks++;
    if (cap_x.size() == NPIX) begin
      if (cap_c[0] != 0 || cap_c[NPIX-1] != 0 || cap_c[1] != 2 ||
          cap_x[0] != 94 || cap_y[0] != 25 || cap_x[NPIX-1] != 100 || cap_y[NPIX-1] != 31) begin
        errors++;
        $display("FAIL tank_corners: got (%0d,%0d)c%0d (%0d,%0d)c%0d second c%0d, expected (94,25)c0 (100,31)c0 second c2",
                 cap_x[0], cap_y[0], cap_c[0], cap_x[NPIX-1], cap_y[NPIX-1], cap_c[NPIX-1], cap_c[1]);
      end
    end else begin
      errors++; $display("FAIL tank_corners: got %0d pixels, expected %0d", cap_x.size(), NPIX);
    end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (i >= cap_x.size()) begin
        errors++; $display("FAIL tank_pixel[%0d]: missing, expected (%0d,%0d) c%0d", i, exp_x[i], exp_y[i], exp_c[i]);
      end else if (cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i] || cap_c[i] != exp_c[i]) begin
        errors++;
        $display("FAIL tank_pixel[%0d]: got (%0d,%0d) c%0d, expected (%0d,%0d) c%0d",
                 i, cap_x[i], cap_y[i], cap_c[i], exp_x[i], exp_y[i], exp_c[i]);
      end
    end
    $display("tile addr=3a type=2 plots=%0d", cap_x.size());

    issue(8'h3A, 2'd0, ok, waits);
    checks++;
    if (!ok || waits != 0) begin
      errors++; $display("FAIL b2b_accept: accepted=%0d after %0d wait cycles, expected accept in cycle after done", ok, waits);
    end
    collect(1'b0, 2'd0, 200);
    model_tile(8'h3A, 0);
    checks++;
    if (cap_x.size() != NPIX || timed_out) begin
      errors++; $display("FAIL empty_count: got %0d plots (timeout=%0d), expected %0d", cap_x.size(), timed_out, NPIX);
    end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (i >= cap_x.size()) begin
        errors++; $display("FAIL empty_pixel[%0d]: missing, expected (%0d,%0d) c0", i, exp_x[i], exp_y[i]);
      end else if (cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i] || cap_c[i] != exp_c[i]) begin
        errors++;
        $display("FAIL empty_pixel[%0d]: got (%0d,%0d) c%0d, expected (%0d,%0d) c%0d",
                 i, cap_x[i], cap_y[i], cap_c[i], exp_x[i], exp_y[i], exp_c[i]);
      end
    end
    $display("tile addr=3a type=0 plots=%0d", cap_x.size());
  endtask

  task automatic test_reset_mid_tile();
    bit ok;
    int waits, nplot, bad;
    issue(8'h11, 2'd1, ok, waits);
    checks++;
    if (!ok) begin errors++; $display("FAIL midreset_accept: req_ready never high"); return; end
    nplot = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      #1;
      if (bus.plot === 1'b1) nplot++;
      if (nplot == 20) break;
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.plot !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL midreset_plot_drop: plot=%b done=%b right after reset, expected 0 0", bus.plot, bus.done);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (bus.req_ready !== 1'b1 || bus.plot !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midreset_idle: %0d cycles not idle after release, expected 0", bad); end
    issue(8'h22, 2'd1, ok, waits);
    collect(1'b0, 2'd0, 200);
    model_tile(8'h22, 1);
    checks++;
    if (!ok || timed_out || cap_x.size() != NPIX) begin
      errors++; $display("FAIL midreset_redraw: accepted=%0d plots=%0d timeout=%0d, expected 1 %0d 0", ok, cap_x.size(), timed_out, NPIX);
    end
    bad = 0;
    for (int i = 0; i < cap_x.size() && i < NPIX; i++)
      if (cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i] || cap_c[i] != exp_c[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midreset_pixels: %0d wrong pixels, expected 0", bad); end
    $display("tile addr=22 type=1 after mid-tile reset plots=%0d", cap_x.size());
  endtask

  task automatic test_random();
    bit ok;
    int waits, a, t, bad;
    for (int n = 0; n < 10; n++) begin
      a = $urandom_range(0, 255);
      t = $urandom_range(0, 3);
      issue(8'(a), 2'(t), ok, waits);
      collect(1'b0, 2'd0, 200);
      model_tile(a, t);
      checks++;
      if (!ok || timed_out || cap_x.size() != NPIX || first_k != 2 || done_k != NPIX + 2) begin
        errors++;
        $display("FAIL rand_timing[%0d]: accepted=%0d plots=%0d first=%0d done=%0d, expected 1 %0d 2 %0d",
                 n, ok, cap_x.size(), first_k, done_k, NPIX, NPIX + 2);
      end
      bad = 0;
      for (int i = 0; i < NPIX; i++)
        if (i >= cap_x.size() || cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i] || cap_c[i] != exp_c[i]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rand_pixels[%0d] addr=%02h type=%0d: %0d wrong pixels, expected 0", n, a, t, bad); end
      checks++;
      if (done_x != exp_x[NPIX-1] || done_y != exp_y[NPIX-1]) begin
        errors++; $display("FAIL rand_hold[%0d]: x,y at done (%0d,%0d), expected (%0d,%0d)",
                           n, done_x, done_y, exp_x[NPIX-1], exp_y[NPIX-1]);
      end
      $display("tile addr=%02h type=%0d plots=%0d wrong=%0d", a, t, cap_x.size(), bad);
    end
  endtask

`ifdef CLEAR_SCREEN_EN
  task automatic test_clear();
    bit ok;
    int waits, bad;
    @(negedge clk);
    bus.clear_req = 1'b1;
    bus.req_valid = 1'b1;
    bus.cell_addr = 8'h55;
    bus.cell_type = 2'd1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL clear_priority: req_ready=%b with clear_req, expected 0", bus.req_ready); end
    @(posedge clk);
    #1;
    bus.clear_req = 1'b0;
    collect(1'b1, 2'd1, 19400);
    checks++;
    if (timed_out || cap_x.size() != 19200 || done_k != last_k + 1) begin
      errors++; $display("FAIL clear_count: plots=%0d done=%0d last=%0d timeout=%0d, expected 19200 plots then done",
                         cap_x.size(), done_k, last_k, timed_out);
    end
    bad = 0;
    for (int i = 0; i < cap_x.size(); i++)
      if (cap_x[i] != i % 160 || cap_y[i] != i / 160 || cap_c[i] != 0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL clear_sweep: %0d pixels off the row-major black sweep, expected 0", bad); end
    checks++;
    if (cap_x.size() > 0) begin
      if (cap_x[cap_x.size()-1] != 159 || cap_y[cap_y.size()-1] != 119) begin
        errors++; $display("FAIL clear_last: got (%0d,%0d), expected (159,119)", cap_x[cap_x.size()-1], cap_y[cap_y.size()-1]);
      end
    end else begin
      errors++; $display("FAIL clear_last: no pixels, expected (159,119)");
    end
    $display("clear: plots=%0d done=%0d", cap_x.size(), done_k);
    issue(8'h55, 2'd1, ok, waits);
    collect(1'b0, 2'd0, 200);
    model_tile(8'h55, 1);
    bad = 0;
    for (int i = 0; i < NPIX; i++)
      if (i >= cap_x.size() || cap_x[i] != exp_x[i] || cap_y[i] != exp_y[i] || cap_c[i] != exp_c[i]) bad++;
    checks++;
    if (!ok || waits != 0 || bad != 0 || cap_x.size() != NPIX) begin
      errors++; $display("FAIL clear_pending: accepted=%0d waits=%0d plots=%0d wrong=%0d, expected 1 0 %0d 0",
                         ok, waits, cap_x.size(), bad, NPIX);
    end
    $display("tile addr=55 type=1 after clear plots=%0d", cap_x.size());
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.cell_addr = 8'h00;
    bus.cell_type = 2'd0;
`ifdef CLEAR_SCREEN_EN
    bus.clear_req = 1'b0;
`endif
    test_reset();
    test_wall();
    test_bullet();
    test_back_to_back();
    test_reset_mid_tile();
    test_random();
`ifdef CLEAR_SCREEN_EN
    test_clear();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
